// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, reset PC, opcode constants and fetch FSM states.
package cpu_pkg;

  localparam int          DEF_ADDR_W   = 64;
  localparam int          DEF_INSTR_W  = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;

  localparam logic [5:0]  OPC_B = 6'b000101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

  function automatic logic is_b_opcode(input logic [5:0] opc);
    return (opc == OPC_B);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small shift-register FIFO between fetch and decode; entry 0 is always the head.
// Flush dominates push; head contents are held when the queue drains or is flushed.
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int DW     = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(QDEPTH):0] count,
  output logic [$clog2(QDEPTH):0] count_next,
  output logic                     head_valid,
  output logic [DW-1:0]            head_data
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int PTR_W = $clog2(QDEPTH);

  logic [DW-1:0]    ent_r [QDEPTH];
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic [PTR_W-1:0] wr_idx_s;
  logic             valid_r;

  // Occupancy next-state and the slot a push lands in (behind the head when popping).
  always_comb begin
    count_nx_s = count_r;
    wr_idx_s   = {PTR_W{1'b0}};
    if (flush) begin
      count_nx_s = {CNT_W{1'b0}};
    end else begin
      count_nx_s = count_r + CNT_W'(push) - CNT_W'(pop);
    end
    if (pop) begin
      wr_idx_s = PTR_W'(count_r - CNT_W'(1'b1));
    end else begin
      wr_idx_s = PTR_W'(count_r);
    end
  end

  // Storage, count and registered head-valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent_r[i] <= {DW{1'b0}};
      end
    end else begin
      count_r <= count_nx_s;
      valid_r <= (count_nx_s != {CNT_W{1'b0}});
      if (!flush) begin
        if (pop) begin
          for (int i = 0; i < QDEPTH - 1; i++) begin
            if (CNT_W'(i + 1) < count_r) begin
              ent_r[i] <= ent_r[i+1];
            end
          end
        end
        if (push) begin
          ent_r[wr_idx_s] <= push_data;
        end
      end
    end
  end

  assign count      = count_r;
  assign count_next = count_nx_s;
  assign head_valid = valid_r;
  assign head_data  = ent_r[0];

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol and occupancy checks for fetch_unit; simulation-only properties, no logic.
module fetch_unit_chk
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = 2
) (
  input logic             clk,
  input logic             reset,
  input fetch_state_e     state,
  input logic             imem_rvalid,
  input logic             push,
  input logic             pop,
  input logic             flush,
  input logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && (count == DEPTH_C)))
    else $error("fetch_queue overflow: push into a full queue");

  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (state != WAIT)))
    else $error("imem_rvalid outside WAIT");

  // The outstanding request must always have a free slot waiting for it.
  a_wait_has_room: assert property (@(posedge clk) disable iff (reset)
    !((state == WAIT) && (count == DEPTH_C)))
    else $error("outstanding plus queued entries exceed QDEPTH");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, epoch-tagged squash on redirect.
// Optional feature macro FETCH_FOLD_B_EN folds unconditional B targets straight into the PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
);

  localparam int               CNT_W   = $clog2(QDEPTH) + 1;
  localparam int               DW      = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  fetch_state_e      state_r;
  fetch_state_e      state_nx_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] pc_nx_s;
  logic [ADDR_W-1:0] redirect_pc_s;
  logic [ADDR_W-1:0] req_pc_r;
  logic              epoch_r;
  logic              req_epoch_r;
  logic              req_r;
  logic              req_nx_s;
  logic              hs_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  q_count_s;
  logic [CNT_W-1:0]  q_count_nx_s;
  logic              q_valid_s;
  logic [DW-1:0]     q_head_s;

  assign hs_s          = req_r & imem_ready;
  assign push_s        = (state_r == WAIT) & imem_rvalid & (req_epoch_r == epoch_r);
  assign pop_s         = q_valid_s & id_ready;
  assign redirect_pc_s = branch_addr & ~ADDR_W'(2'b11);

  // FSM next state and sequential PC advance on an accepted request.
  always_comb begin
    state_nx_s = state_r;
    seq_pc_s   = pc_r;
    case (state_r)
      IDLE: begin
        state_nx_s = ISSUE;
      end
      ISSUE: begin
        if (hs_s) begin
          state_nx_s = WAIT;
          seq_pc_s   = pc_r + ADDR_W'(3'd4);
        end else begin
          state_nx_s = ISSUE;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

`ifdef FETCH_FOLD_B_EN
  logic              fold_s;
  logic [ADDR_W-1:0] fold_pc_s;

  // A current-epoch B overrides the pc+4 applied at issue; stale responses never fold.
  assign fold_s    = push_s & is_b_opcode(imem_rdata[31:26]);
  assign fold_pc_s = req_pc_r + {{(ADDR_W-28){imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
  assign pc_nx_s   = pc_src ? redirect_pc_s : (fold_s ? fold_pc_s : seq_pc_s);
`else
  assign pc_nx_s   = pc_src ? redirect_pc_s : seq_pc_s;
`endif

  // Request is only offered while the queue can absorb its response.
  assign req_nx_s = (state_nx_s == ISSUE) && (q_count_nx_s < DEPTH_C);

  // PC, epoch, FSM and in-flight request bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      epoch_r     <= 1'b0;
      req_r       <= 1'b0;
      req_pc_r    <= RESET_PC;
      req_epoch_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      epoch_r <= epoch_r ^ pc_src;
      req_r   <= req_nx_s;
      if (hs_s) begin
        req_pc_r    <= pc_r;
        req_epoch_r <= epoch_r;
      end
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .DW     (DW)
  ) u_queue (
    .clk        (clk),
    .rst        (reset),
    .push       (push_s),
    .push_data  ({req_pc_r, imem_rdata}),
    .pop        (pop_s),
    .flush      (pc_src),
    .count      (q_count_s),
    .count_next (q_count_nx_s),
    .head_valid (q_valid_s),
    .head_data  (q_head_s)
  );

  fetch_unit_chk #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .state       (state_r),
    .imem_rvalid (imem_rvalid),
    .push        (push_s),
    .pop         (pop_s),
    .flush       (pc_src),
    .count       (q_count_s)
  );

  assign imem_req  = req_r;
  assign imem_addr = pc_r;
  assign if_valid  = q_valid_s;
  assign if_pc     = q_head_s[DW-1:INSTR_W];
  assign if_instr  = q_head_s[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases queue expected requests/outputs,
// a negedge monitor models instruction memory and checks every handshake and pop.
module tb_fetch_unit;

  localparam int AW = 64;
  localparam int IW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } out_t;

  logic          clk;
  logic          reset;
  logic          pc_src;
  logic [AW-1:0] branch_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          id_ready;

  int            n_checks;
  int            n_fail;
  logic [AW-1:0] exp_req_q[$];
  out_t          exp_out_q[$];
  int            allow;
  int            lat;
  logic          rsp_pend;
  int            rsp_wait;
  logic [AW-1:0] rsp_addr;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_src      (pc_src),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 64'h10) return 32'h17FF_FFFF;
    return {6'b110011, a[25:0]};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [AW-1:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic exp_out(input logic [AW-1:0] a);
    exp_out_q.push_back({a, mem_word(a)});
  endtask

  // Memory model and monitor: inputs change and outputs are sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rsp_pend) begin
        if (rsp_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(rsp_addr);
          rsp_pend    = 1'b0;
        end else begin
          rsp_wait--;
        end
      end
      imem_ready = (allow > 0);
      if (!reset && imem_req && imem_ready) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got request to %h, required no request", imem_addr);
        end else begin
          check("req_addr", 96'(imem_addr), 96'(exp_req_q.pop_front()));
        end
        allow--;
        rsp_pend = 1'b1;
        rsp_wait = lat;
        rsp_addr = imem_addr;
      end
      if (!reset && if_valid && id_ready) begin
        if (exp_out_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got pc %h instr %h, required no output", if_pc, if_instr);
        end else begin
          check("out_pc_instr", {if_pc, if_instr}, exp_out_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    pc_src      = 1'b0;
    branch_addr = 64'h0;
    allow       = 0;
    rsp_pend    = 1'b0;
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    #1;
    check("rst_imem_req", 96'(imem_req), 96'(1'b0));
    check("rst_imem_addr", 96'(imem_addr), 96'(64'h0));
    check("rst_if_valid", 96'(if_valid), 96'(1'b0));
    check("rst_if_instr", 96'(if_instr), 96'(32'h0));
    check("rst_if_pc", 96'(if_pc), 96'(64'h0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_req_level(input string name, input int level, input int budget);
    int k;
    k = 0;
    while (exp_req_q.size() != level && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (exp_req_q.size() != level) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d requests pending, required %0d", name, exp_req_q.size(), level);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_req_q.size() != 0 || exp_out_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (exp_req_q.size() != 0 || exp_out_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d requests and %0d outputs outstanding, required 0",
               name, exp_req_q.size(), exp_out_q.size());
      exp_req_q.delete();
      exp_out_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    lat      = 0;
    id_ready = 1'b1;
    imem_rdata = 32'h0;
    do_reset();

    // Straight-line fetch, response one cycle after accept.
    exp_req(64'h0); exp_req(64'h4); exp_req(64'h8);
    exp_out(64'h0); exp_out(64'h4); exp_out(64'h8);
    allow = 3;
    wait_drain("t1", 100);

    // Decode stalls: queue fills to two, requests stop, then drain and resume at 8.
    do_reset();
    id_ready = 1'b0;
    exp_req(64'h0); exp_req(64'h4); exp_req(64'h8);
    exp_out(64'h0); exp_out(64'h4); exp_out(64'h8);
    allow = 3;
    repeat (10) @(posedge clk);
    #1;
    check("t2_req_blocked", 96'(imem_req), 96'(1'b0));
    check("t2_head_valid", 96'(if_valid), 96'(1'b1));
    check("t2_head_pc", 96'(if_pc), 96'(64'h0));
    check("t2_pending_req", 96'(exp_req_q.size()), 96'(1));
    id_ready = 1'b1;
    wait_drain("t2", 100);

    // Redirect while waiting for addr 8: its response is dropped, fetch restarts at 0x100.
    do_reset();
    lat = 3;
    exp_req(64'h0); exp_req(64'h4); exp_req(64'h8);
    exp_out(64'h0); exp_out(64'h4);
    allow = 3;
    wait_req_level("t3_wait", 0, 100);
    #1;
    pc_src      = 1'b1;
    branch_addr = 64'h102;
    exp_req(64'h100);
    exp_out(64'h100);
    allow = allow + 1;
    @(posedge clk);
    #1;
    pc_src = 1'b0;
    check("t3_state_wait_req", 96'(imem_req), 96'(1'b0));
    check("t3_masked_pc", 96'(imem_addr), 96'(64'h100));
    wait_drain("t3", 100);

    // Redirect coinciding with an ISSUE handshake and a pop.
    do_reset();
    lat = 0;
    exp_req(64'h0); exp_req(64'h4);
    exp_out(64'h0);
    allow = 2;
    wait_req_level("t4_first", 1, 100);
    @(posedge clk);
    #1;
    pc_src      = 1'b1;
    branch_addr = 64'h100;
    exp_req(64'h100);
    exp_out(64'h100);
    allow = allow + 1;
    @(posedge clk);
    #1;
    pc_src = 1'b0;
    check("t4_flushed", 96'(if_valid), 96'(1'b0));
    check("t4_pop_done", 96'(exp_out_q.size()), 96'(1));
    wait_drain("t4", 100);

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    lat = 3;
    exp_req(64'h0); exp_req(64'h4); exp_req(64'h8); exp_req(64'hC);
    exp_out(64'h0); exp_out(64'h4); exp_out(64'h8);
    allow = 4;
    wait_req_level("t5_wait", 0, 100);
    #2;
    check("t5_pre_addr", 96'(imem_addr), 96'(64'h10));
    do_reset();
    exp_req(64'h0);
    exp_out(64'h0);
    allow = 1;
    wait_drain("t5", 100);

    // Unconditional B (offset -4) at 0x10.
    do_reset();
    lat = 0;
    exp_req(64'h0); exp_req(64'h4); exp_req(64'h8); exp_req(64'hC); exp_req(64'h10);
    exp_out(64'h0); exp_out(64'h4); exp_out(64'h8); exp_out(64'hC); exp_out(64'h10);
`ifdef FETCH_FOLD_B_EN
    exp_req(64'hC);
    exp_out(64'hC);
`else
    exp_req(64'h14);
    exp_out(64'h14);
`endif
    allow = 6;
    wait_drain("t6", 200);

    // Back-to-back redirects, last wins; PC wraps past the top of the address space.
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    pc_src      = 1'b1;
    branch_addr = 64'h200;
    @(posedge clk);
    #1;
    branch_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    pc_src = 1'b0;
    check("t7_req", 96'(imem_req), 96'(1'b1));
    check("t7_addr", 96'(imem_addr), 96'(64'hFFFF_FFFF_FFFF_FFFC));
    exp_req(64'hFFFF_FFFF_FFFF_FFFC); exp_req(64'h0);
    exp_out(64'hFFFF_FFFF_FFFF_FFFC); exp_out(64'h0);
    allow = 2;
    wait_drain("t7", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
